lock_code_writer: RTL
=====================

# lock_code_writer

Programming-side counterpart to the keypad lock checker: captures eight hex digits from the synchronized keypad strobe/code stream and writes them into the 32-bit combination register the checker reads. Sits between the key synchronizer (strobe + 5-bit code) and the lock FSM's `seq` input. Entry is permitted only while `prog_req` is held (driven high by top-level logic when the lock is OPEN). A new code replaces the stored one only after an explicit confirm.

## Interface
- `DEFAULT_SEQ`, 32'h12345678: value of `seq` after reset.
- `TIMEOUT_CYCLES`, 1000: inactivity limit in clk cycles (10 s at 100 Hz); used only with the timeout feature.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `key_strobe` in 1: synchronized key-held level from the key synchronizer.
- `key_code` in 5: code of the pressed key (0-15 digits, 16 clear/confirm, 17 backspace, 18-19 unused).
- `prog_req` in 1: programming permitted (level).
- `seq` out 32: stored combination, digit 0 in [31:28].
- `prog_active` out 1: high in ENTRY or CONFIRM.
- `digit_cnt` out 4: digits captured so far, 0-8.
- `commit` out 1: one-cycle pulse when `seq` is updated.
- `err` out 1: one-cycle pulse on rejected entry or timeout.

## Operation
- Press detect: `press = key_strobe & ~strobe_q`, where `strobe_q` is `key_strobe` registered. `key_code` is sampled in the press cycle. Holding a key produces exactly one press.
- Shadow register `shadow[31:0]` holds the code being entered. `seq` changes only on commit.
- States:
  - **IDLE**
    - `prog_req` = 1 → ENTRY; `shadow` ← 0, `digit_cnt` ← 0.
    - A press in the transition cycle is ignored.
  - **ENTRY**
    - Digit press (code < 16): `shadow` ← {`shadow`[27:0], `code`[3:0]}, `digit_cnt`+1. On the 8th digit → CONFIRM.
    - Code 16: `shadow` ← 0, `digit_cnt` ← 0; stay in ENTRY.
    - Code 17: if `digit_cnt` > 0, `shadow` ← {4'h0, `shadow`[31:4]} and `digit_cnt`−1; if `digit_cnt` = 0, no effect.
    - Codes 18-19: ignored.
  - **CONFIRM**
    - Code 16: `seq` ← `shadow`, pulse `commit` → IDLE.
    - Digit press: pulse `err` → IDLE; `seq` unchanged.
    - Code 17: `shadow` ← {4'h0, `shadow`[31:4]}, `digit_cnt` ← 7 → ENTRY.
    - Codes 18-19: ignored.
- `prog_req` low in ENTRY or CONFIRM → IDLE silently (no `err`), `seq` unchanged. This takes priority over a press in the same cycle.
- `digit_cnt` never exceeds 8 and never wraps below 0.

## Timing
- All state, `shadow`, `seq`, `digit_cnt`, `commit` and `err` update on the clk edge where `press` is true. `seq` is valid the cycle after the confirm press edge; `commit` is high for that cycle only.
- `prog_active` is registered and follows the state with no extra delay.
- Reset values: `seq` = `DEFAULT_SEQ`; `prog_active`, `commit`, `err` = 0; `digit_cnt` = 0; state IDLE; `strobe_q` = 0; `shadow` = 0; timeout counter = 0.
- Reset mid-entry discards `shadow` and restores `DEFAULT_SEQ`.
- `strobe_q` = 0 after reset, so a key already held when reset releases counts as one press on the first edge.

## Configuration
- `LOCK_CODE_WRITER_TIMEOUT_EN` defined:
  - Counter clears on every press and on entry to ENTRY; it increments every cycle in ENTRY/CONFIRM.
  - When the counter reaches `TIMEOUT_CYCLES`−1 → IDLE with `err` pulse; `seq` unchanged.
  - A press in the expiry cycle wins and clears the counter.
- Not defined: no counter is built; ENTRY/CONFIRM persist indefinitely while `prog_req` is high.

## Structure
- `lock_pkg` holds:
  - `KEY_CLR` = 5'd16 and `KEY_BKSP` = 5'd17.
  - `SEQ_DIGITS` = 8.
  - `writer_state_t` (IDLE, ENTRY, CONFIRM).
  - The existing lock `state_t`.
- One sub-module, `key_press_edge`:
  - Ports: clk, rst, key_strobe, key_code → press, press_code.
  - Registers `strobe_q`; output is combinational in the press cycle.

## Test plan
- Reset → `seq` = 32'h12345678, `prog_active` = 0, `commit` = `err` = 0.
- `prog_req` = 1, presses 8,7,6,5,4,3,2,1 then 16 → `digit_cnt` steps 1..8, `commit` pulses once, `seq` = 32'h87654321, `prog_active` = 0.
- In ENTRY, presses 1,2,3, then 17, then 9 → `shadow` low digits 0x129, `digit_cnt` = 3. Key held 20 cycles counts once.
- 8 digits then digit 5 in CONFIRM → `err` pulse, `seq` unchanged, state IDLE. Separately, dropping `prog_req` after 4 digits → IDLE, no `err`.
- Assert `rst` after 6 digits → `seq` = `DEFAULT_SEQ`, `digit_cnt` = 0 immediately.
- With `LOCK_CODE_WRITER_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 20: 2 digits then idle 20 cycles → `err` at cycle 20, IDLE. A press at cycle 19 → no timeout.

Source files
------------

// File: rtl/lock_pkg.sv
// lock_pkg: shared definitions for the keypad lock and its code writer.
//   KEY_CLR / KEY_BKSP : special key codes from the key synchronizer
//   SEQ_DIGITS         : number of hex digits in a combination
//   writer_state_t     : code writer FSM states
//   state_t            : lock checker FSM states
//   is_digit()         : true for key codes 0-15
package lock_pkg;

  localparam logic [4:0]  KEY_CLR    = 5'd16;
  localparam logic [4:0]  KEY_BKSP   = 5'd17;
  localparam int unsigned SEQ_DIGITS = 8;

  typedef enum logic [1:0] {
    StIdle,
    StEntry,
    StConfirm
  } writer_state_t;

  typedef enum logic [1:0] {
    LockLocked,
    LockEntry,
    LockOpen,
    LockAlarm
  } state_t;

  function automatic logic is_digit(input logic [4:0] code);
    return code < KEY_CLR;
  endfunction

endpackage

// File: rtl/key_press_edge.sv
// key_press_edge: turns the synchronized key-held level into a one-cycle press.
//   clk        in  : system clock, rising edge
//   rst        in  : asynchronous active-high reset
//   key_strobe in  : key-held level
//   key_code   in  : code of the held key
//   press      out : high in the first cycle the key is held (combinational)
//   press_code out : key code valid in the press cycle
module key_press_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_strobe,
  input  logic [4:0] key_code,
  output logic       press,
  output logic [4:0] press_code
);

  logic strobe_q;

  // Cleared by reset so a key held through reset release yields one press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_q <= 1'b0;
    end else begin
      strobe_q <= key_strobe;
    end
  end

  assign press      = key_strobe & ~strobe_q;
  assign press_code = key_code;

endmodule

// File: rtl/lock_code_writer.sv
// lock_code_writer: captures eight hex digits while programming is permitted and,
// after an explicit confirm, writes them into the combination register.
//   clk         in  : system clock, rising edge
//   rst         in  : asynchronous active-high reset
//   key_strobe  in  : synchronized key-held level
//   key_code    in  : key code (0-15 digit, 16 clear/confirm, 17 backspace)
//   prog_req    in  : programming permitted (level)
//   seq         out : stored combination, digit 0 in [31:28]
//   prog_active out : high in ENTRY or CONFIRM
//   digit_cnt   out : digits captured so far, 0-8
//   commit      out : one-cycle pulse when seq is updated
//   err         out : one-cycle pulse on rejected entry or timeout
// Optional: define LOCK_CODE_WRITER_TIMEOUT_EN to abandon entry after
// TIMEOUT_CYCLES cycles without a press.
module lock_code_writer
  import lock_pkg::*;
#(
  parameter logic [31:0] DEFAULT_SEQ    = 32'h12345678,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_strobe,
  input  logic [4:0]  key_code,
  input  logic        prog_req,
  output logic [31:0] seq,
  output logic        prog_active,
  output logic [3:0]  digit_cnt,
  output logic        commit,
  output logic        err
);

  localparam logic [3:0] LastDigit = 4'(SEQ_DIGITS - 1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  logic          press;
  logic [4:0]    press_code;
  logic          expired;

  writer_state_t state_q, state_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   seq_q, seq_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          commit_q, commit_d;
  logic          err_q, err_d;

  key_press_edge u_key_press_edge (
    .clk        (clk),
    .rst        (rst),
    .key_strobe (key_strobe),
    .key_code   (key_code),
    .press      (press),
    .press_code (press_code)
  );

`ifdef LOCK_CODE_WRITER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);

  logic [TmoW-1:0] tmo_q, tmo_d;

  assign expired = (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  // Counts only while staying in ENTRY/CONFIRM without a press; entering from
  // IDLE, any press, and any return to IDLE restart it from zero.
  always_comb begin
    tmo_d = '0;
    if ((state_q != StIdle) && (state_d != StIdle) && !press) begin
      tmo_d = tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign expired = 1'b0;
`endif

  // Every return to IDLE drops the partial code, so digit_cnt reads 0 there.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    seq_d    = seq_q;
    commit_d = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (prog_req) begin
          state_d  = StEntry;
          shadow_d = '0;
          cnt_d    = '0;
        end
      end
      StEntry: begin
        if (!prog_req) begin
          state_d  = StIdle;
          shadow_d = '0;
          cnt_d    = '0;
        end else if (press) begin
          if (is_digit(press_code)) begin
            shadow_d = {shadow_q[27:0], press_code[3:0]};
            cnt_d    = cnt_q + 4'd1;
            if (cnt_q == LastDigit) begin
              state_d = StConfirm;
            end
          end else if (press_code == KEY_CLR) begin
            shadow_d = '0;
            cnt_d    = '0;
          end else if ((press_code == KEY_BKSP) && (cnt_q != 4'd0)) begin
            shadow_d = {4'h0, shadow_q[31:4]};
            cnt_d    = cnt_q - 4'd1;
          end
        end else if (expired) begin
          state_d  = StIdle;
          shadow_d = '0;
          cnt_d    = '0;
          err_d    = 1'b1;
        end
      end
      StConfirm: begin
        if (!prog_req) begin
          state_d  = StIdle;
          shadow_d = '0;
          cnt_d    = '0;
        end else if (press) begin
          if (is_digit(press_code)) begin
            state_d  = StIdle;
            shadow_d = '0;
            cnt_d    = '0;
            err_d    = 1'b1;
          end else if (press_code == KEY_CLR) begin
            seq_d    = shadow_q;
            commit_d = 1'b1;
            state_d  = StIdle;
            shadow_d = '0;
            cnt_d    = '0;
          end else if (press_code == KEY_BKSP) begin
            shadow_d = {4'h0, shadow_q[31:4]};
            cnt_d    = LastDigit;
            state_d  = StEntry;
          end
        end else if (expired) begin
          state_d  = StIdle;
          shadow_d = '0;
          cnt_d    = '0;
          err_d    = 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        shadow_d = '0;
        cnt_d    = '0;
      end
    endcase
    active_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      seq_q    <= DEFAULT_SEQ;
      cnt_q    <= '0;
      active_q <= 1'b0;
      commit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      seq_q    <= seq_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      commit_q <= commit_d;
      err_q    <= err_d;
    end
  end

  assign seq         = seq_q;
  assign prog_active = active_q;
  assign digit_cnt   = cnt_q;
  assign commit      = commit_q;
  assign err         = err_q;

endmodule
